// File: rtl/decoder_nx_scan.sv
// decoder_nx_scan: registered N-to-2**N one-hot decoder.
// Direct mode decodes each accepted select code (valid/ready handshake).
// Scan mode walks a single active bit across all outputs, holding each
// output for dwell+1 cycles.
// Optional build macro DECODER_ONESHOT_EN: scan makes a single pass, then
// clears d and pulses done for one cycle.
module decoder_nx_scan #(
    parameter int unsigned N       = 3,
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic               i_valid,
    output logic               i_ready,
    input  logic [N-1:0]       i,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2**N-1:0]    d,
    output logic               d_valid
`ifdef DECODER_ONESHOT_EN
    ,
    output logic               done
`endif
);

    localparam int unsigned W = 2**N;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [N-1:0]       idx_q;
    logic [N-1:0]       idx_inc;
    logic [DWELL_W-1:0] cnt_q;
    logic [W-1:0]       onehot_sel;
    logic [W-1:0]       onehot_next;
`ifdef DECODER_ONESHOT_EN
    logic               finished_q;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state follows en/mode directly every cycle
    always_comb begin
        state_d = IDLE;
        if (en) begin
            state_d = mode ? SCAN : DIRECT;
        end
    end

    // Handshake output: ready only while sitting in DIRECT
    always_comb begin
        i_ready = (state_q == DIRECT);
    end

    // One-hot codes for the select input and the next scan position
    always_comb begin
        idx_inc     = idx_q + N'(1);
        onehot_sel  = W'(1) << i;
        onehot_next = W'(1) << idx_inc;
    end

    // Output datapath. Actions key off the state being entered (state_d) so
    // that entry clears/loads and en drops take effect on the very next edge;
    // comparing against state_q detects entry versus staying.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d       <= '0;
            d_valid <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
`ifdef DECODER_ONESHOT_EN
            done       <= 1'b0;
            finished_q <= 1'b0;
`endif
        end else begin
`ifdef DECODER_ONESHOT_EN
            done <= 1'b0;
`endif
            case (state_d)
                DIRECT: begin
                    idx_q <= '0;
                    cnt_q <= '0;
`ifdef DECODER_ONESHOT_EN
                    finished_q <= 1'b0;
`endif
                    if (state_q != DIRECT) begin
                        d       <= '0;
                        d_valid <= 1'b0;
                    end else if (i_valid && i_ready) begin
                        d       <= onehot_sel;
                        d_valid <= 1'b1;
                    end
                end
                SCAN: begin
                    if (state_q != SCAN) begin
                        idx_q   <= '0;
                        cnt_q   <= dwell;
                        d       <= W'(1);
                        d_valid <= 1'b1;
`ifdef DECODER_ONESHOT_EN
                        finished_q <= 1'b0;
`endif
                    end
`ifdef DECODER_ONESHOT_EN
                    else if (finished_q) begin
                        d       <= '0;
                        d_valid <= 1'b0;
                    end
`endif
                    else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - DWELL_W'(1);
                    end
`ifdef DECODER_ONESHOT_EN
                    else if (&idx_q) begin
                        d          <= '0;
                        d_valid    <= 1'b0;
                        done       <= 1'b1;
                        finished_q <= 1'b1;
                    end
`endif
                    else begin
                        idx_q   <= idx_inc;
                        cnt_q   <= dwell;
                        d       <= onehot_next;
                        d_valid <= 1'b1;
                    end
                end
                default: begin
                    d       <= '0;
                    d_valid <= 1'b0;
                    idx_q   <= '0;
                    cnt_q   <= '0;
`ifdef DECODER_ONESHOT_EN
                    finished_q <= 1'b0;
`endif
                end
            endcase
        end
    end

endmodule

// File: doc/decoder_nx_scan.md
Name: decoder_nx_scan

Overview:
Registered, parametrised N-to-2^N binary-to-one-hot decoder with a valid/ready input handshake and an autonomous scan mode. Direct mode decodes each accepted select code into a registered one-hot word. Scan mode walks the active bit across all outputs with a programmable dwell, for display multiplexing and row/column strobing. It replaces fixed-width combinational decoders wherever a registered, handshaken or self-sequencing one-hot output is needed.

Parameters:
N, 3, select width; output width is 2**N (N=3 gives the 3-to-8 case)
DWELL_W, 8, width of the dwell input and the internal dwell counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  block enable; 0 forces outputs to zero and returns to IDLE
mode  input  1  0 = direct decode, 1 = scan
i_valid  input  1  select code valid
i_ready  output  1  block accepts i this cycle
i  input  N  binary select code
dwell  input  DWELL_W  scan hold count; each output is held dwell+1 cycles
d  output  2**N  registered one-hot output
d_valid  output  1  d holds a meaningful one-hot value
done  output  1  present only with DECODER_ONESHOT_EN; see Optional Feature

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low. All state updates on the rising edge of clk.
- Reset values:
  - d=0, d_valid=0, i_ready=0, done=0.
  - state=IDLE, scan index=0, dwell counter=0.
- States:
  - IDLE: en=0.
  - DIRECT: en=1, mode=0.
  - SCAN: en=1, mode=1.
  - The next state is chosen every cycle from en and mode. Any state goes to IDLE when en=0.
- IDLE:
  - Next edge: d=0, d_valid=0, i_ready=0, scan index=0.
- DIRECT:
  - i_ready=1 combinationally while state is DIRECT.
  - A transfer occurs when i_valid && i_ready. On that edge d <= 1<<i and d_valid <= 1, giving one-cycle latency.
  - d holds its value until the next transfer.
  - Back-to-back transfers are allowed, one per cycle.
  - On entry to DIRECT from any other state, d=0 and d_valid=0 until the first transfer.
- SCAN:
  - i_ready=0; i and i_valid are ignored.
  - On entry, index=0, d=1 and d_valid=1 on the first SCAN cycle's edge, and the dwell counter loads dwell.
  - Each cycle the counter decrements. When it reaches 0, the index increments, d shifts to 1<<index and the counter reloads from the current dwell. dwell is therefore sampled only at reload.
  - The index wraps from 2**N-1 to 0; the scan is continuous.
  - dwell=0 advances the index every cycle.
- Mode change mid-operation:
  - DIRECT->SCAN always restarts at index 0.
  - SCAN->DIRECT clears d the next edge.
  - An i_valid present in the same cycle as the switch back to DIRECT is accepted only once i_ready=1, i.e. from the first DIRECT cycle.
- en drop in any state: the next edge gives d=0 and d_valid=0, and any in-flight transfer is discarded.
- Asynchronous reset mid-scan or mid-transfer: all outputs go to reset values immediately, without waiting for a clock edge.
- Invariant: d is either zero or one-hot. d_valid=1 if and only if d is non-zero.

Optional Feature:
- Macro: DECODER_ONESHOT_EN.
- Defined:
  - The done output exists.
  - SCAN performs exactly one pass, 0..2**N-1. After the last output's dwell expires, d=0, d_valid=0 and a one-cycle done=1 pulse is issued, then the block sits idle in SCAN.
  - A new pass requires leaving SCAN (mode=0 or en=0) and re-entering.
- Undefined: no done port, and the scan wraps continuously.

Test Plan:
- Reset: assert rst_n=0 mid-scan, asynchronously -> d=0, d_valid=0, i_ready=0 immediately; after release with en=0, outputs stay 0.
- Direct sweep (N=3): en=1, mode=0, drive i=0..7 with i_valid=1 on consecutive cycles -> one cycle later d=01,02,04,08,10,20,40,80 (hex), d_valid=1 throughout, i_ready=1.
- Handshake hold: accept i=5 (d=20h), then i_valid=0 with i=2 for 4 cycles -> d stays 20h.
- Scan with dwell (dwell=2): mode=1 -> d=01h for 3 cycles, then 02h for 3 cycles, ..., 80h, then wraps to 01h; i_ready=0. With dwell=0 -> d changes every cycle.
- Mode/enable interruption: mid-scan at d=10h, switch to mode=0 -> d=0 on the next edge, then i=3 gives d=08h; return to mode=1 -> restarts at 01h; drop en -> d=0 and d_valid=0 on the next edge.
- Optional feature (DECODER_ONESHOT_EN, dwell=1): one pass of 16 cycles, then d=0 and a single-cycle done=1 pulse; d stays 0 until mode toggles 1->0->1.
